// File: rtl/npc_pkg.sv
// ============================================================================
// Module      : npc_pkg
// Description : Shared types and constants for the npc core PC sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_JAL  = 4'd1,
        OP_JALR = 4'd2,
        OP_BEQ  = 4'd3,
        OP_BNE  = 4'd4,
        OP_BLT  = 4'd5,
        OP_BGE  = 4'd6,
        OP_BLTU = 4'd7,
        OP_BGEU = 4'd8
    } ex_op_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int unsigned ILEN_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/pc_branch_resolve.sv
// ============================================================================
// Module      : pc_branch_resolve
// Description : Combinational taken/target/alignment resolution of one op.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_branch_resolve
    import npc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic            ex_valid,
    input  ex_op_t          ex_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_eq,
    input  logic            ex_lt,
    input  logic            ex_ltu,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic            w_cond;
    logic            w_bad_align;
    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_reg_rel;

    always_comb begin
        w_cond = 1'b0;
        case (ex_op)
            OP_JAL:  w_cond = 1'b1;
            OP_JALR: w_cond = 1'b1;
            OP_BEQ:  w_cond = ex_eq;
            OP_BNE:  w_cond = !ex_eq;
            OP_BLT:  w_cond = ex_lt;
            OP_BGE:  w_cond = !ex_lt;
            OP_BLTU: w_cond = ex_ltu;
            OP_BGEU: w_cond = !ex_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_pc_rel  = ex_pc + ex_imm;
    assign w_reg_rel = (ex_rs1 + ex_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign target    = (ex_op == OP_JALR) ? w_reg_rel : w_pc_rel;
    assign taken     = ex_valid & w_cond;

    // Compressed support relaxes the check to halfword alignment.
    generate
        if (C_EXT) begin : g_align_half
            assign w_bad_align = target[0];
        end else begin : g_align_word
            assign w_bad_align = target[1];
        end
    endgenerate

    assign misaligned = taken & w_bad_align;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Architectural PC register, redirect priority and fetch request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import npc_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter bit          C_EXT    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  ex_op_t          ex_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_eq,
    input  logic            ex_lt,
    input  logic            ex_ltu,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_ready,
    output logic            flush,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] c_RESET_PC  = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] c_PC_STRIDE = XLEN'(ILEN_BYTES);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_fetch_valid;
    logic            w_valid_nxt;
    logic            r_flush;
    logic            w_flush_nxt;
    logic            r_misalign;
    logic            w_mis_nxt;
    logic [XLEN-1:0] r_misalign_addr;
    logic [XLEN-1:0] w_mis_addr_nxt;

    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;

    pc_branch_resolve #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_resolve (
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .ex_eq      (ex_eq),
        .ex_lt      (ex_lt),
        .ex_ltu     (ex_ltu),
        .taken      (w_taken),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Redirects abort any outstanding handshake; halt outranks every redirect.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_fetch_pc;
        w_valid_nxt    = r_fetch_valid;
        w_flush_nxt    = 1'b0;
        w_mis_nxt      = 1'b0;
        w_mis_addr_nxt = r_misalign_addr;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_valid_nxt = 1'b1;
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_HALT;
                    w_valid_nxt = 1'b0;
                end else if (trap_valid) begin
                    w_pc_nxt    = trap_vec;
                    w_flush_nxt = 1'b1;
                end else if (mret_valid) begin
                    w_pc_nxt    = mepc;
                    w_flush_nxt = 1'b1;
                end else if (w_taken && w_misaligned) begin
                    w_mis_nxt      = 1'b1;
                    w_mis_addr_nxt = w_target;
                end else if (w_taken) begin
                    w_pc_nxt    = w_target;
                    w_flush_nxt = 1'b1;
                end else if (r_fetch_valid && fetch_ready) begin
                    w_pc_nxt = r_fetch_pc + c_PC_STRIDE;
                end
            end
            ST_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc      <= c_RESET_PC;
            r_fetch_valid   <= 1'b0;
            r_flush         <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_fetch_pc      <= w_pc_nxt;
            r_fetch_valid   <= w_valid_nxt;
            r_flush         <= w_flush_nxt;
            r_misalign      <= w_mis_nxt;
            r_misalign_addr <= w_mis_addr_nxt;
        end
    end

    assign fetch_pc      = r_fetch_pc;
    assign fetch_valid   = r_fetch_valid;
    assign flush         = r_flush;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalign_addr;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed, table-driven self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
    import npc_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    ex_op_t      ex_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        ex_eq;
    logic        ex_lt;
    logic        ex_ltu;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        mret_valid;
    logic [31:0] mepc;
    logic        halt;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        misalign;
    logic [31:0] misalign_addr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        ex_op_t      op;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic        exp_mis;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[16];

    pc_sequencer #(
        .XLEN     (32),
        .RESET_PC (64'h8000_0000),
        .C_EXT    (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_op         (ex_op),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_eq         (ex_eq),
        .ex_lt         (ex_lt),
        .ex_ltu        (ex_ltu),
        .trap_valid    (trap_valid),
        .trap_vec      (trap_vec),
        .mret_valid    (mret_valid),
        .mepc          (mepc),
        .halt          (halt),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .misalign      (misalign),
        .misalign_addr (misalign_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ex_valid   = 1'b0;
        ex_op      = OP_NONE;
        ex_pc      = '0;
        ex_imm     = '0;
        ex_rs1     = '0;
        ex_eq      = 1'b0;
        ex_lt      = 1'b0;
        ex_ltu     = 1'b0;
        trap_valid = 1'b0;
        trap_vec   = '0;
        mret_valid = 1'b0;
        mepc       = '0;
        halt       = 1'b0;
    endtask

    initial begin
        // valid op eq lt ltu imm exp_pc flush mis addr   (ex_pc = 8000_0040)
        vecs[0]  = '{1'b1, OP_BEQ,  1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h8000_0050, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, OP_BEQ,  1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h8000_0050, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, OP_BNE,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h8000_0038, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, OP_BNE,  1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h8000_0038, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, OP_BLT,  1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h8000_0140, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, OP_BLT,  1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h8000_0140, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, OP_BGE,  1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h8000_0044, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, OP_BGE,  1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h8000_0044, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, OP_BLTU, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h8000_0048, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, OP_BLTU, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h8000_0048, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, OP_BGEU, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 32'h8000_004C, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b1, OP_BGEU, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h8000_004C, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, OP_NONE, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h8000_004C, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, OP_JAL,  1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h8000_004C, 1'b0, 1'b0, 32'h0};
        vecs[14] = '{1'b1, OP_JAL,  1'b0, 1'b0, 1'b0, 32'h7FFF_FFC0, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{1'b1, OP_BEQ,  1'b1, 1'b0, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0052};

        clear_inputs();
        fetch_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset_pc", fetch_pc, 32'h8000_0000);
        chk("reset_valid", {31'b0, fetch_valid}, 32'h0);
        chk("reset_flush", {31'b0, flush}, 32'h0);
        chk("reset_misalign", {31'b0, misalign}, 32'h0);
        chk("reset_misalign_addr", misalign_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("boot_valid", {31'b0, fetch_valid}, 32'h0);

        // Boot: valid rises after one cycle, then sequential advance.
        tick();
        chk("first_valid", {31'b0, fetch_valid}, 32'h1);
        chk("first_pc", fetch_pc, 32'h8000_0000);
        tick();
        chk("seq_pc1", fetch_pc, 32'h8000_0004);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", fetch_pc, 32'h8000_0004);
        end
        fetch_ready = 1'b1;
        tick();
        chk("seq_pc2", fetch_pc, 32'h8000_0008);

        // BNE taken then not taken.
        ex_valid = 1'b1; ex_op = OP_BNE; ex_pc = 32'h8000_0010; ex_imm = 32'hFFFF_FFF0; ex_eq = 1'b0;
        tick();
        chk("bne_pc", fetch_pc, 32'h8000_0000);
        chk("bne_flush", {31'b0, flush}, 32'h1);
        ex_valid = 1'b0;
        tick();
        chk("bne_flush_drop", {31'b0, flush}, 32'h0);
        chk("bne_seq_pc", fetch_pc, 32'h8000_0004);
        ex_valid = 1'b1; ex_eq = 1'b1;
        tick();
        chk("bne_nt_pc", fetch_pc, 32'h8000_0008);
        chk("bne_nt_flush", {31'b0, flush}, 32'h0);

        // JALR alignment fault, then aligned JALR.
        fetch_ready = 1'b0;
        ex_op = OP_JALR; ex_rs1 = 32'h8000_1001; ex_imm = 32'h2;
        tick();
        chk("jalr_mis", {31'b0, misalign}, 32'h1);
        chk("jalr_mis_addr", misalign_addr, 32'h8000_1002);
        chk("jalr_mis_pc", fetch_pc, 32'h8000_0008);
        chk("jalr_mis_flush", {31'b0, flush}, 32'h0);
        ex_imm = 32'h3;
        tick();
        chk("jalr_pc", fetch_pc, 32'h8000_1004);
        chk("jalr_flush", {31'b0, flush}, 32'h1);
        chk("jalr_mis_drop", {31'b0, misalign}, 32'h0);

        // Trap beats mret beats JAL.
        clear_inputs();
        ex_valid = 1'b1; ex_op = OP_JAL; ex_pc = 32'h8000_0000; ex_imm = 32'h40;
        trap_valid = 1'b1; trap_vec = 32'h8000_0100;
        mret_valid = 1'b1; mepc = 32'h8000_0200;
        tick();
        chk("trap_pc", fetch_pc, 32'h8000_0100);
        chk("trap_flush", {31'b0, flush}, 32'h1);
        clear_inputs();
        tick();
        chk("trap_flush_drop", {31'b0, flush}, 32'h0);
        chk("trap_hold_pc", fetch_pc, 32'h8000_0100);
        ex_valid = 1'b1; ex_op = OP_JAL; ex_pc = 32'h8000_0000; ex_imm = 32'h40;
        mret_valid = 1'b1; mepc = 32'h8000_0200;
        tick();
        chk("mret_pc", fetch_pc, 32'h8000_0200);
        chk("mret_flush", {31'b0, flush}, 32'h1);
        clear_inputs();

        // Branch decision table with fetch stalled.
        ex_pc = 32'h8000_0040;
        for (int i = 0; i < 16; i++) begin
            ex_valid = vecs[i].valid;
            ex_op    = vecs[i].op;
            ex_eq    = vecs[i].eq;
            ex_lt    = vecs[i].lt;
            ex_ltu   = vecs[i].ltu;
            ex_imm   = vecs[i].imm;
            tick();
            chk($sformatf("vec%0d_pc", i), fetch_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
            chk($sformatf("vec%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
            if (vecs[i].exp_mis)
                chk($sformatf("vec%0d_addr", i), misalign_addr, vecs[i].exp_addr);
        end
        clear_inputs();

        // Halt together with a redirect: halt wins, then everything frozen.
        fetch_ready = 1'b1;
        halt = 1'b1; ex_valid = 1'b1; ex_op = OP_JAL; ex_pc = 32'h8000_0040; ex_imm = 32'h40;
        tick();
        chk("halt_valid", {31'b0, fetch_valid}, 32'h0);
        chk("halt_flush", {31'b0, flush}, 32'h0);
        chk("halt_pc", fetch_pc, 32'h0000_0000);
        halt = 1'b0; trap_valid = 1'b1; trap_vec = 32'h8000_0100;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halted_valid", {31'b0, fetch_valid}, 32'h0);
            chk("halted_pc", fetch_pc, 32'h0000_0000);
            chk("halted_flush", {31'b0, flush}, 32'h0);
        end

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", fetch_pc, 32'h8000_0000);
        chk("async_rst_valid", {31'b0, fetch_valid}, 32'h0);
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
        chk("rerun_valid", {31'b0, fetch_valid}, 32'h1);
        tick();
        chk("rerun_pc", fetch_pc, 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
